// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, constants and fetch-entry type for the
//               instruction fetch stage and its fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown on the output when empty
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // Sequential fetch stride in bytes
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO of fetched {pc, inst} entries with
//               push, pop and flush. Flush has priority over push and pop.
//               A push is accepted on a full queue only with a pop in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t wr_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wr_next;
  logic [PTR_W-1:0] w_rd_next;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

  // Guard the handshakes locally so occupancy can never over/underflow
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;

  assign w_wr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  assign head = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush discards everything at the edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= w_wr_next;
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful behind valid pointers
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wr_entry;
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch stage. Owns the PC, fetches one word per
//               cycle from a combinational instruction memory into a small
//               fetch queue, and handles branch/jump redirects by flushing.
//               Optional macro FETCH_PERF_EN adds the fetch_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  fetch_entry_t      w_wr_entry;
  fetch_entry_t      w_head;

  assign imem_addr = r_pc;

  // A full queue can still take the fetched word if the head leaves this cycle
  assign w_pop  = if_valid && if_ready;
  assign w_push = !redirect_valid && (!w_full || w_pop);

  assign w_wr_entry.pc   = r_pc;
  assign w_wr_entry.inst = imem_dout;

  assign if_valid = !w_empty;
  assign if_inst  = w_empty ? NOP_INST : w_head.inst;
  assign if_pc    = w_empty ? '0       : w_head.pc;

  // PC register: redirect target (word aligned) beats sequential advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .wr_entry (w_wr_entry),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;

  // Counts accepted pushes only; redirect cycles never push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
    end else if (w_push) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. Memory word k at
//               byte address 4k holds value k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_ready;

  logic [31:0] imem_addr, imem_dout;
  logic        if_valid;
  logic [31:0] if_inst, if_pc;

  logic [31:0] imem_addr1, imem_dout1;
  logic        if_valid1;
  logic [31:0] if_inst1, if_pc1;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, fetch_count1;
`endif

  int n_tests;
  int n_fail;

  assign imem_dout  = imem_addr  >> 2;
  assign imem_dout1 = imem_addr1 >> 2;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr1),
    .imem_dout      (imem_dout1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid1),
    .if_inst        (if_inst1),
    .if_pc          (if_pc1),
    .if_ready       (if_ready)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    logic        chk1;
    logic [31:0] e_pc1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic rdy,
                              logic e_valid, logic [31:0] e_pc, logic [31:0] e_inst,
                              logic [31:0] e_addr, logic chk1, logic [31:0] e_pc1);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_inst = e_inst; v.e_addr = e_addr;
    v.chk1 = chk1; v.e_pc1 = e_pc1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b1;

    // Sequence 1: free-running fetch with a wrapping-PC twin instance
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 32'h13, 32'h00, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h04, 1, 32'hFFFF_FFF8));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h1, 32'h08, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8, 32'h2, 32'h0C, 1, 32'h0000_0000));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC, 32'h3, 32'h10, 0, 32'h0));
    // Sequence 2: stall until full, drain, redirect when full, redirect with pop
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h13, 32'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h04, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4, 32'h1, 32'h0C, 0, 0));
    vecs.push_back(mk(0, 1, 32'h103, 0, 1, 32'h8, 32'h2, 32'h10, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h13, 32'h100, 0, 0));
    vecs.push_back(mk(0, 1, 32'h200, 1, 1, 32'h100, 32'h40, 32'h104, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h13, 32'h200, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h200, 32'h80, 32'h204, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h200, 32'h80, 32'h208, 0, 0));

    // Reset state while held through an edge
    step();
    chk("rst.valid", {31'b0, if_valid}, 32'h0);
    chk("rst.inst", if_inst, 32'h13);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.addr_wrap", imem_addr1, 32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    chk("rst.count", fetch_count, 32'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
      end
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      if_ready       = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d.valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d.pc", i), if_pc, vecs[i].e_pc);
      chk($sformatf("v%0d.inst", i), if_inst, vecs[i].e_inst);
      chk($sformatf("v%0d.addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].chk1)
        chk($sformatf("v%0d.wrap_pc", i), if_pc1, vecs[i].e_pc1);
      step();
    end

    // Asynchronous reset mid-cycle while the queue is full
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    #1;
    chk("areset.pre_valid", {31'b0, if_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("areset.valid", {31'b0, if_valid}, 32'h0);
    chk("areset.pc", if_pc, 32'h0);
    chk("areset.inst", if_inst, 32'h13);
    chk("areset.addr", imem_addr, 32'h0);
    step();
    reset = 1'b1;
    #1;
    chk("arel.valid", {31'b0, if_valid}, 32'h0);
    chk("arel.addr", imem_addr, 32'h0);
    step();
    chk("arel.first_valid", {31'b0, if_valid}, 32'h1);
    chk("arel.first_pc", if_pc, 32'h0);
    chk("arel.first_inst", if_inst, 32'h0);

    // 10 pushes, a redirect, 3 more pushes
    reset = 1'b0;
    #1;
`ifdef FETCH_PERF_EN
    chk("perf.rst_count", fetch_count, 32'h0);
`endif
    reset = 1'b1;
    if_ready = 1'b1;
    repeat (10) step();
    chk("perf.addr10", imem_addr, 32'h28);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    chk("perf.redir_valid", {31'b0, if_valid}, 32'h0);
    repeat (3) step();
    chk("perf.addr_end", imem_addr, 32'h40C);
    chk("perf.head_pc", if_pc, 32'h408);
`ifdef FETCH_PERF_EN
    chk("perf.count", fetch_count, 32'd13);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
